// File: rtl/dte_pkg.sv
// ---------------------------------------------------------------------------
// dte_pkg
//   Shared types for the DTE request sequencer: front-end request kinds,
//   diagnostic and misc function codes, the queued request/reply records,
//   the "nothing waiting" time sentinel and the sequencer FSM states.
// ---------------------------------------------------------------------------
package dte_pkg;

    // Front-end request kind carried alongside every request/reply.
    typedef enum logic [2:0] {
        dteDiagFunc    = 3'd0,
        dteDiagRead    = 3'd1,
        dteDiagWrite   = 3'd2,
        dteReleaseEBUS = 3'd3,
        dteMisc        = 3'd4
    } tFEReqType;

    // Misc function codes (carried in the 7-bit diag field for dteMisc).
    typedef enum logic [6:0] {
        miscClrCrom    = 7'o00,
        miscDrvEbusReq = 7'o01,
        miscClrEbusReq = 7'o02,
        miscSetRun     = 7'o03
    } tMiscFuncType;

    // A few well-known diagnostic function codes.
    typedef enum logic [6:0] {
        diagStopClk    = 7'o000,
        diagStartClk   = 7'o001,
        diagCondStep   = 7'o004,
        diagClrReset   = 7'o006,
        diagSetReset   = 7'o007,
        diagReadEbus   = 7'o070
    } tDiagFunction;

    typedef struct packed {
        tFEReqType   req_type;
        logic [6:0]  diag;
        logic [0:35] data;
        logic [63:0] req_time;
    } tDteReq;

    typedef struct packed {
        logic [63:0] rpl_time;
        tFEReqType   rpl_type;
        logic [6:0]  diag;
        logic [0:35] data;
    } tDteRpl;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } tSeqState;

    // A request offered with this time is acknowledged but never queued.
    localparam logic [63:0] NO_REQ_TIME  = '1;
    // Reply data reported when the DTE never answers (timeout build only).
    localparam logic [0:35] TIMEOUT_DATA = 36'o777777777777;

endpackage

// File: rtl/dte_sync_fifo.sv
// ---------------------------------------------------------------------------
// dte_sync_fifo
//   Single-clock FIFO of an arbitrary record type T. A push and a pop in the
//   same cycle both take effect, including when full (the pop frees the slot
//   being written) or empty (the pop is a no-op, the push lands).
//   rd_data_o shows the head entry, or all zeros while empty.
// Ports
//   clk, resetN         clock, asynchronous active-low reset
//   push_i, wr_data_i   write request and data
//   pop_i               remove head entry
//   rd_data_o           head entry
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module dte_sync_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   push_i,
    input  T                       wr_data_i,
    input  logic                   pop_i,
    output T                       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: storage has no reset; occupancy is tracked by the pointers and
    // count, and the head is masked while empty, so stale data never leaks.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/dte_req_sequencer.sv
// ---------------------------------------------------------------------------
// dte_req_sequencer
//   Feeds front-end requests to the DTE EBUS stage strictly in order. Each
//   request waits in a FIFO until the free-running tick counter reaches its
//   scheduled time, is presented to the DTE, and the DTE reply is stamped with
//   the tick of arrival and queued for the front end.
// Build option
//   DTE_REQ_TIMEOUT_EN  when defined, a request left unanswered TIMEOUT ticks
//                       after issAck produces an all-ones reply and the
//                       sequencer moves on; otherwise it waits forever.
// Ports
//   clk, resetN                         clock, asynchronous active-low reset
//   reqValid/reqReady                   front-end request handshake
//   reqType/diagReq/reqData/reqTime     request fields (all-ones time = none)
//   issValid/issAck                     request presented to / taken by DTE
//   issType/issDiag/issData             presented request fields
//   rspValid/rspData                    DTE completion pulse and EBUS data
//   rplValid/rplReady                   reply queue handshake to front end
//   rplTime/rplType/rplDiag/rplData     head reply fields
//   ticks                               free-running tick counter
//   busy                                request issued and not yet replied
// ---------------------------------------------------------------------------
module dte_req_sequencer
    import dte_pkg::*;
#(
    parameter int unsigned REQ_DEPTH = 8,
    parameter int unsigned RSP_DEPTH = 8,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [2:0]  reqType,
    input  logic [6:0]  diagReq,
    input  logic [0:35] reqData,
    input  logic [63:0] reqTime,
    output logic        issValid,
    input  logic        issAck,
    output logic [2:0]  issType,
    output logic [6:0]  issDiag,
    output logic [0:35] issData,
    input  logic        rspValid,
    input  logic [0:35] rspData,
    output logic        rplValid,
    input  logic        rplReady,
    output logic [63:0] rplTime,
    output logic [2:0]  rplType,
    output logic [6:0]  rplDiag,
    output logic [0:35] rplData,
    output logic [63:0] ticks,
    output logic        busy
);

    tSeqState    state_q;
    logic [63:0] ticks_q;
    logic [63:0] ticks_d;
    logic        iss_valid_q;
    tFEReqType   iss_type_q;
    logic [6:0]  iss_diag_q;
    logic [0:35] iss_data_q;
    logic        busy_q;

    tDteReq      req_wr_data;
    tDteReq      req_head;
    logic        req_push;
    logic        req_pop;
    logic        req_full;
    logic        req_empty;
    logic [$clog2(REQ_DEPTH):0] unused_req_count;

    tDteRpl      rpl_wr_data;
    tDteRpl      rpl_head;
    logic        rpl_push;
    logic        rpl_pop;
    logic        rpl_full;
    logic        rpl_empty;
    logic [$clog2(RSP_DEPTH):0] unused_rpl_count;

    logic        can_issue;
    logic        timeout_hit;

    // ------------------------------------------------------------ tick counter
    assign ticks_d = ticks_q + 64'd1;   // wraps naturally at 2^64

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ticks_q <= '0;
        end else begin
            ticks_q <= ticks_d;
        end
    end

    // ----------------------------------------------------------- request queue
    assign reqReady = !req_full;
    // Sentinel-timed requests complete the handshake but are dropped here.
    assign req_push = reqValid && reqReady && (reqTime != NO_REQ_TIME);
    assign req_pop  = (state_q == ST_ISSUE) && issAck;

    always_comb begin
        req_wr_data          = '0;
        req_wr_data.req_type = tFEReqType'(reqType);
        req_wr_data.diag     = diagReq;
        req_wr_data.data     = reqData;
        req_wr_data.req_time = reqTime;
    end

    dte_sync_fifo #(
        .T     (tDteReq),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .push_i    (req_push),
        .wr_data_i (req_wr_data),
        .pop_i     (req_pop),
        .rd_data_o (req_head),
        .full_o    (req_full),
        .empty_o   (req_empty),
        .count_o   (unused_req_count)
    );

    // ------------------------------------------------------------- reply queue
    // Only one request is ever in flight, and it is only issued when a reply
    // slot is free, so the reply push below always finds room.
    assign rpl_pop  = !rpl_empty && rplReady;
    assign rpl_push = (state_q == ST_WAIT) && (rspValid || timeout_hit);

    // NOTE: every field gets a default before the conditional parts so the
    // combinational block never infers a latch.
    always_comb begin
        rpl_wr_data          = '0;
        rpl_wr_data.rpl_time = ticks_q;
        rpl_wr_data.rpl_type = iss_type_q;
        rpl_wr_data.diag     = iss_diag_q;
        rpl_wr_data.data     = timeout_hit ? TIMEOUT_DATA : rspData;
    end

    dte_sync_fifo #(
        .T     (tDteRpl),
        .DEPTH (RSP_DEPTH)
    ) u_rpl_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .push_i    (rpl_push),
        .wr_data_i (rpl_wr_data),
        .pop_i     (rpl_pop),
        .rd_data_o (rpl_head),
        .full_o    (rpl_full),
        .empty_o   (rpl_empty),
        .count_o   (unused_rpl_count)
    );

    // A reply popped this cycle frees its slot in time for the next issue.
    assign can_issue = !req_empty
                    && (req_head.req_time <= ticks_q)
                    && (!rpl_full || rpl_pop);

    // ------------------------------------------------------------ timeout
`ifdef DTE_REQ_TIMEOUT_EN
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q;

    // tmo_q is 0 in the first WAIT cycle, so TMO_LAST lands TIMEOUT ticks
    // after the issAck cycle. A real reply in that cycle still wins.
    assign timeout_hit = (state_q == ST_WAIT) && !rspValid && (tmo_q == TMO_LAST);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT;
    assign timeout_hit        = 1'b0;
`endif

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            iss_valid_q <= 1'b0;
            iss_type_q  <= dteDiagFunc;
            iss_diag_q  <= '0;
            iss_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef DTE_REQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (can_issue) begin
                        state_q     <= ST_ISSUE;
                        iss_valid_q <= 1'b1;
                        iss_type_q  <= req_head.req_type;
                        iss_diag_q  <= req_head.diag;
                        iss_data_q  <= req_head.data;
                    end
                end
                ST_ISSUE: begin
                    // A rspValid in the ack cycle is not looked at here.
                    if (issAck) begin
                        state_q     <= ST_WAIT;
                        iss_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef DTE_REQ_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (rpl_push) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
`ifdef DTE_REQ_TIMEOUT_EN
                    else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    assign issValid = iss_valid_q;
    assign issType  = iss_type_q;
    assign issDiag  = iss_diag_q;
    assign issData  = iss_data_q;
    assign busy     = busy_q;
    assign ticks    = ticks_q;

    assign rplValid = !rpl_empty;
    assign rplTime  = rpl_head.rpl_time;
    assign rplType  = rpl_head.rpl_type;
    assign rplDiag  = rpl_head.diag;
    assign rplData  = rpl_head.data;

endmodule

// File: tb/tb_dte_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dte_req_sequencer
//   Directed bench for dte_req_sequencer: a table of single-request vectors
//   followed by hand-written sequences for scheduling, back-pressure,
//   reply-queue full, sentinel requests, reset and (when DTE_REQ_TIMEOUT_EN
//   is defined) the reply timeout.
// ---------------------------------------------------------------------------
module tb_dte_req_sequencer;
    import dte_pkg::*;

    localparam int unsigned REQ_DEPTH = 8;
    localparam int unsigned RSP_DEPTH = 8;
    localparam int unsigned TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic [2:0]  reqType;
    logic [6:0]  diagReq;
    logic [35:0] reqData;
    logic [63:0] reqTime;
    logic        issValid;
    logic        issAck;
    logic [2:0]  issType;
    logic [6:0]  issDiag;
    logic [35:0] issData;
    logic        rspValid;
    logic [35:0] rspData;
    logic        rplValid;
    logic        rplReady;
    logic [63:0] rplTime;
    logic [2:0]  rplType;
    logic [6:0]  rplDiag;
    logic [35:0] rplData;
    logic [63:0] ticks;
    logic        busy;

    always #5 clk = ~clk;

    dte_req_sequencer #(
        .REQ_DEPTH (REQ_DEPTH),
        .RSP_DEPTH (RSP_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqType  (reqType),
        .diagReq  (diagReq),
        .reqData  (reqData),
        .reqTime  (reqTime),
        .issValid (issValid),
        .issAck   (issAck),
        .issType  (issType),
        .issDiag  (issDiag),
        .issData  (issData),
        .rspValid (rspValid),
        .rspData  (rspData),
        .rplValid (rplValid),
        .rplReady (rplReady),
        .rplTime  (rplTime),
        .rplType  (rplType),
        .rplDiag  (rplDiag),
        .rplData  (rplData),
        .ticks    (ticks),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    // Independent tick reference: reset to 0, +1 every edge out of reset.
    logic [63:0] tb_tick;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) tb_tick <= '0;
        else         tb_tick <= tb_tick + 64'd1;
    end

    typedef struct {
        logic [2:0]  typ;
        logic [6:0]  diag;
        logic [35:0] data;
        logic [63:0] rtime;
        logic [35:0] rsp;
        int          delay;
        logic [2:0]  exp_type;
        logic [6:0]  exp_diag;
        logic [35:0] exp_data;
        logic [35:0] exp_rpl;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Sample/drive point: 1ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] t, input logic [6:0] d,
                        input logic [35:0] dat, input logic [63:0] tm);
        reqValid = 1'b1;
        reqType  = t;
        diagReq  = d;
        reqData  = dat;
        reqTime  = tm;
        step();
        reqValid = 1'b0;
    endtask

    task automatic wait_iss(input string name);
        int n = 0;
        while (!issValid && n < 100) begin
            step();
            n++;
        end
        check(name, {63'd0, issValid}, 64'd1);
    endtask

    // Ack the presented request, then answer in the first WAIT cycle.
    task automatic ack_rsp(input logic [35:0] rsp);
        issAck = 1'b1;
        step();
        issAck   = 1'b0;
        rspValid = 1'b1;
        rspData  = rsp;
        step();
        rspValid = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [35:0] exp_data);
        check({name, "_vld"}, {63'd0, rplValid}, 64'd1);
        check({name, "_data"}, {28'd0, rplData}, {28'd0, exp_data});
        rplReady = 1'b1;
        step();
        rplReady = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] rsp_tick;
        string       p;
        p = $sformatf("vec%0d", idx);
        push(v.typ, v.diag, v.data, v.rtime);
        check({p, "_iss_n1"}, {63'd0, issValid}, 64'd0);
        step();
        check({p, "_iss_n2"}, {63'd0, issValid}, 64'd1);
        check({p, "_iss_type"}, {61'd0, issType}, {61'd0, v.exp_type});
        check({p, "_iss_diag"}, {57'd0, issDiag}, {57'd0, v.exp_diag});
        check({p, "_iss_data"}, {28'd0, issData}, {28'd0, v.exp_data});
        issAck = 1'b1;
        step();
        issAck = 1'b0;
        check({p, "_busy"}, {63'd0, busy}, 64'd1);
        check({p, "_iss_drop"}, {63'd0, issValid}, 64'd0);
        repeat (v.delay) step();
        rspValid = 1'b1;
        rspData  = v.rsp;
        rsp_tick = tb_tick;
        step();
        rspValid = 1'b0;
        check({p, "_idle"}, {63'd0, busy}, 64'd0);
        check({p, "_rpl_type"}, {61'd0, rplType}, {61'd0, v.exp_type});
        check({p, "_rpl_diag"}, {57'd0, rplDiag}, {57'd0, v.exp_diag});
        check({p, "_rpl_time"}, rplTime, rsp_tick);
        pop_check({p, "_rpl"}, v.exp_rpl);
        check({p, "_rpl_empty"}, {63'd0, rplValid}, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] target;
        logic [63:0] first;
        logic [63:0] ack_tick;
        int          n;

        vecs[0] = '{dteDiagFunc,    7'o70, 36'o0,            64'd0, 36'o123,          0,
                    3'd0, 7'o70, 36'o0,            36'o123};
        vecs[1] = '{dteDiagRead,    7'o71, 36'o0,            64'd2, 36'o777000111222, 3,
                    3'd1, 7'o71, 36'o0,            36'o777000111222};
        vecs[2] = '{dteDiagWrite,   7'o72, 36'o123456701234, 64'd1, 36'o0,            1,
                    3'd2, 7'o72, 36'o123456701234, 36'o0};
        vecs[3] = '{dteReleaseEBUS, 7'o00, 36'o400000000000, 64'd0, 36'o1,            2,
                    3'd3, 7'o00, 36'o400000000000, 36'o1};
        vecs[4] = '{dteMisc,        7'o05, 36'o777777777777, 64'd0, 36'o525252525252, 0,
                    3'd4, 7'o05, 36'o777777777777, 36'o525252525252};

        resetN = 1'b0; reqValid = 1'b0; reqType = '0; diagReq = '0; reqData = '0;
        reqTime = '0; issAck = 1'b0; rspValid = 1'b0; rspData = '0; rplReady = 1'b0;

        // ---------------------------------------------------------- reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_ticks", ticks, 64'd0);
        check("rst_iss", {63'd0, issValid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rpl", {63'd0, rplValid}, 64'd0);
        check("rst_rpl_data", {28'd0, rplData}, 64'd0);
        resetN = 1'b1;
        step();
        check("ticks_1", ticks, 64'd1);
        check("rst_ready", {63'd0, reqReady}, 64'd1);
        step();
        step();
        check("ticks_3", ticks, 64'd3);

        // --------------------------------------------------- vector table
        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // rspValid while idle is ignored
        rspValid = 1'b1; rspData = 36'o666;
        step();
        rspValid = 1'b0;
        step();
        check("idle_rsp_ignored", {63'd0, rplValid}, 64'd0);

        // issAck and rspValid in the same cycle: response ignored
        push(dteDiagRead, 7'o33, 36'o0, 64'd0);
        wait_iss("same_iss");
        issAck = 1'b1; rspValid = 1'b1; rspData = 36'o444;
        step();
        issAck = 1'b0; rspValid = 1'b0;
        check("same_busy", {63'd0, busy}, 64'd1);
        check("same_no_rpl", {63'd0, rplValid}, 64'd0);
        step();
        rspValid = 1'b1; rspData = 36'o555;
        step();
        rspValid = 1'b0;
        pop_check("same_rpl", 36'o555);

        // ------------------------------------------- scheduled issue time
        target = tb_tick + 64'd20;
        push(dteDiagFunc, 7'o01, 36'o7, target);
        n = 0;
        while (!issValid && n < 60) begin
            step();
            n++;
        end
        first = tb_tick;
        check("sched_seen", {63'd0, issValid}, 64'd1);
        check("sched_not_early", {63'd0, first >= target}, 64'd1);
        check("sched_on_time", {63'd0, first <= target + 64'd1}, 64'd1);
        ack_rsp(36'o17);
        pop_check("sched_rpl", 36'o17);

        // ----------------------------- request FIFO full, DTE stalled
        for (int i = 0; i <= REQ_DEPTH; i++) begin
            check($sformatf("fill_ready%0d", i), {63'd0, reqReady},
                  (i < REQ_DEPTH) ? 64'd1 : 64'd0);
            reqValid = 1'b1; reqType = dteDiagWrite; diagReq = 7'o2;
            reqData = 36'(i); reqTime = 64'd0;
            step();
        end
        reqValid = 1'b0;
        for (int i = 0; i < REQ_DEPTH; i++) begin
            wait_iss($sformatf("drain_iss%0d", i));
            check($sformatf("drain_data%0d", i), {28'd0, issData}, 64'(i));
            issAck = 1'b1;
            step();
            issAck = 1'b0;
            check($sformatf("drain_ready%0d", i), {63'd0, reqReady}, 64'd1);
            rspValid = 1'b1; rspData = 36'o1000 + 36'(i);
            step();
            rspValid = 1'b0;
            pop_check($sformatf("drain_rpl%0d", i), 36'o1000 + 36'(i));
        end
        repeat (4) step();
        check("ninth_dropped", {63'd0, issValid}, 64'd0);

        // ---------------------------------------------- reply FIFO full
        for (int i = 0; i < RSP_DEPTH; i++) begin
            push(dteDiagRead, 7'o4, 36'(i), 64'd0);
            wait_iss($sformatf("rfull_iss%0d", i));
            ack_rsp(36'o2000 + 36'(i));
        end
        push(dteDiagRead, 7'o4, 36'd8, 64'd0);
        repeat (6) step();
        check("rfull_blocked", {63'd0, issValid}, 64'd0);
        check("rfull_head", {28'd0, rplData}, 64'o2000);
        rplReady = 1'b1;
        step();
        rplReady = 1'b0;
        check("rfull_resume", {63'd0, issValid}, 64'd1);
        check("rfull_resume_data", {28'd0, issData}, 64'd8);
        ack_rsp(36'o2010);
        for (int i = 1; i <= RSP_DEPTH; i++) begin
            pop_check($sformatf("rfull_pop%0d", i),
                      (i == RSP_DEPTH) ? 36'o2010 : 36'o2000 + 36'(i));
        end
        check("rfull_empty", {63'd0, rplValid}, 64'd0);

        // ------------------------------------ sentinel request not queued
        for (int i = 0; i < REQ_DEPTH - 1; i++) push(dteMisc, 7'o1, 36'h30 + 36'(i), 64'd0);
        check("sent_ready_pre", {63'd0, reqReady}, 64'd1);
        push(dteMisc, 7'o1, 36'hBAD, NO_REQ_TIME);
        check("sent_ready_post", {63'd0, reqReady}, 64'd1);
        push(dteMisc, 7'o1, 36'h37, 64'd0);
        check("sent_full", {63'd0, reqReady}, 64'd0);
        for (int i = 0; i < REQ_DEPTH; i++) begin
            wait_iss($sformatf("sent_iss%0d", i));
            check($sformatf("sent_data%0d", i), {28'd0, issData}, 64'h30 + 64'(i));
            ack_rsp(36'd0);
            pop_check($sformatf("sent_rpl%0d", i), 36'd0);
        end
        repeat (5) step();
        check("sent_nothing", {63'd0, issValid}, 64'd0);

        // ------------------------------------- reset mid-transaction
        push(dteDiagFunc, 7'o5, 36'o1, 64'd0);
        push(dteDiagFunc, 7'o5, 36'o2, 64'd0);
        wait_iss("mid_iss");
        resetN = 1'b0;
        #1;
        check("mid_rst_iss", {63'd0, issValid}, 64'd0);
        check("mid_rst_ticks", ticks, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        step();
        resetN = 1'b1;
        repeat (5) step();
        check("mid_dropped", {63'd0, issValid}, 64'd0);
        check("mid_ready", {63'd0, reqReady}, 64'd1);
        check("mid_ticks", ticks, 64'd5);

`ifdef DTE_REQ_TIMEOUT_EN
        // ---------------------------------------------- reply timeout
        push(dteMisc, 7'o3, 36'o42, 64'd0);
        wait_iss("tmo_iss");
        issAck   = 1'b1;
        ack_tick = tb_tick;
        step();
        issAck = 1'b0;
        n = 0;
        while (!rplValid && n < 60) begin
            step();
            n++;
        end
        check("tmo_busy", {63'd0, busy}, 64'd0);
        check("tmo_type", {61'd0, rplType}, 64'd4);
        check("tmo_time", rplTime, ack_tick + 64'd16);
        rspValid = 1'b1; rspData = 36'o11;
        step();
        rspValid = 1'b0;
        pop_check("tmo_rpl", 36'o777777777777);
        check("tmo_late_ignored", {63'd0, rplValid}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
